// File: rtl/fizzle_pkg.sv
// Shared definitions for the fizzlefade engine: FSM states and stock LFSR configurations.
package fizzle_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    WRITE,
    WAIT,
    LAST,
    DONE
  } fade_state_e;

  localparam int               LFSR15_LEN  = 15;
  localparam logic [14:0]      LFSR15_TAPS = 15'b110000000000000;
  localparam int               LFSR4_LEN   = 4;
  localparam logic [3:0]       LFSR4_TAPS  = 4'b1100;

endpackage

// File: rtl/fizzle_fade_lfsr.sv
// Fibonacci LFSR with synchronous load of a seed; shifts left, feedback into bit 0.
module lfsr #(
  parameter int             LEN  = 15,
  parameter logic [LEN-1:0] TAPS = 15'b110000000000000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [LEN-1:0] seed,
  output logic [LEN-1:0] sreg
);

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= seed;
    end else if (en) begin
      sreg <= {sreg[LEN-2:0], ^(sreg & TAPS)};
    end
  end

endmodule

// File: rtl/fizzle_fade.sv
// Fizzlefade engine: one colour write per framebuffer address in LFSR order, address 0 last.
// Optional macro FIZZLE_FADE_PROGRESS_EN adds the accepted-write counter output `progress`.
module fizzle_fade
  import fizzle_pkg::*;
#(
  parameter int                  FB_WIDTH  = 160,
  parameter int                  FB_HEIGHT = 120,
  parameter int                  LFSR_LEN  = LFSR15_LEN,
  parameter logic [LFSR_LEN-1:0] LFSR_TAPS = LFSR15_TAPS,
  parameter int                  CIDXW     = 4,
  parameter int                  RATEW     = 16,
  localparam int                 FB_ADDRW  = $clog2(FB_WIDTH*FB_HEIGHT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [RATEW-1:0]    rate,
  input  logic [CIDXW-1:0]    colr,
  input  logic                fb_ready,
  output logic                fb_we,
  output logic [FB_ADDRW-1:0] fb_addr,
  output logic [CIDXW-1:0]    fb_colr,
  output logic                busy,
  output logic                done
`ifdef FIZZLE_FADE_PROGRESS_EN
  , output logic [FB_ADDRW:0] progress
`endif
);

  localparam logic [LFSR_LEN-1:0] NPIX = LFSR_LEN'(FB_WIDTH*FB_HEIGHT);
  localparam logic [LFSR_LEN-1:0] SEED = LFSR_LEN'(1);

  fade_state_e         r_state, w_state_n;
  logic [RATEW-1:0]    r_cnt, w_cnt_n;
  logic [RATEW-1:0]    r_rate, w_rate_n;
  logic                r_final, w_final_n;
  logic                w_we_n, w_busy_n, w_done_n;
  logic [FB_ADDRW-1:0] w_addr_n;
  logic [CIDXW-1:0]    w_colr_n;
  logic                w_adv, w_reseed;
  logic [LFSR_LEN-1:0] w_sreg, w_sreg_nxt;

  // Reseeding rides on the LFSR's own synchronous load so the sequence restarts at 1.
  lfsr #(.LEN(LFSR_LEN), .TAPS(LFSR_TAPS)) u_lfsr (
    .clk (clk),
    .rst (rst | w_reseed),
    .en  (w_adv),
    .seed(SEED),
    .sreg(w_sreg)
  );

  assign w_sreg_nxt = {w_sreg[LFSR_LEN-2:0], ^(w_sreg & LFSR_TAPS)};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rate  <= '0;
      r_final <= 1'b0;
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_colr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_rate  <= w_rate_n;
      r_final <= w_final_n;
      fb_we   <= w_we_n;
      fb_addr <= w_addr_n;
      fb_colr <= w_colr_n;
      busy    <= w_busy_n;
      done    <= w_done_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_rate_n  = r_rate;
    w_final_n = r_final;
    w_we_n    = fb_we;
    w_addr_n  = fb_addr;
    w_colr_n  = fb_colr;
    w_busy_n  = busy;
    w_done_n  = 1'b0;
    w_adv     = 1'b0;
    w_reseed  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_colr_n  = colr;
          w_rate_n  = rate;
          w_cnt_n   = rate;
          w_final_n = 1'b0;
          w_reseed  = 1'b1;
          w_busy_n  = 1'b1;
          w_state_n = SCAN;
        end
      end
      SCAN: begin
        if (w_sreg < NPIX) begin
          w_addr_n  = w_sreg[FB_ADDRW-1:0];
          w_we_n    = 1'b1;
          w_state_n = WRITE;
        end else begin
          w_adv     = 1'b1;
          w_state_n = (w_sreg_nxt == SEED) ? LAST : SCAN;
        end
      end
      WRITE: begin
        if (fb_ready) begin
          w_we_n  = 1'b0;
          w_cnt_n = r_rate;
          if (r_final) begin
            w_done_n  = 1'b1;
            w_state_n = DONE;
          end else begin
            w_adv = 1'b1;
            if (w_sreg_nxt == SEED)  w_state_n = LAST;
            else if (r_rate != '0)   w_state_n = WAIT;
            else                     w_state_n = SCAN;
          end
        end
      end
      WAIT: begin
        if (r_cnt <= RATEW'(1)) w_state_n = SCAN;
        else                    w_cnt_n   = r_cnt - RATEW'(1);
      end
      LAST: begin
        w_addr_n  = '0;
        w_we_n    = 1'b1;
        w_final_n = 1'b1;
        w_state_n = WRITE;
      end
      DONE: begin
        w_busy_n  = 1'b0;
        w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

`ifdef FIZZLE_FADE_PROGRESS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      progress <= '0;
    end else if (r_state == IDLE && start) begin
      progress <= '0;
    end else if (fb_we && fb_ready) begin
      progress <= progress + (FB_ADDRW+1)'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fizzle_fade.sv
// Self-checking bench for fizzle_fade: 4x3 table/random fades against an LFSR-walk model, plus a full 160x120 fade.
module tb_fizzle_fade;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s_start, s_ready, s_we, s_busy, s_done;
  logic [15:0] s_rate;
  logic [3:0]  s_colr, s_colr_o, s_addr;
  logic        l_start, l_ready, l_we, l_busy, l_done;
  logic [15:0] l_rate;
  logic [3:0]  l_colr, l_colr_o;
  logic [14:0] l_addr;
`ifdef FIZZLE_FADE_PROGRESS_EN
  logic [4:0]  s_prog;
  logic [15:0] l_prog;
`endif

  fizzle_fade #(.FB_WIDTH(4), .FB_HEIGHT(3), .LFSR_LEN(4), .LFSR_TAPS(4'b1100)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .rate(s_rate), .colr(s_colr), .fb_ready(s_ready),
    .fb_we(s_we), .fb_addr(s_addr), .fb_colr(s_colr_o), .busy(s_busy), .done(s_done)
`ifdef FIZZLE_FADE_PROGRESS_EN
    , .progress(s_prog)
`endif
  );

  fizzle_fade dut_l (
    .clk(clk), .rst(rst), .start(l_start), .rate(l_rate), .colr(l_colr), .fb_ready(l_ready),
    .fb_we(l_we), .fb_addr(l_addr), .fb_colr(l_colr_o), .busy(l_busy), .done(l_done)
`ifdef FIZZLE_FADE_PROGRESS_EN
    , .progress(l_prog)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference walk: every LFSR state in order, which of them are written, and the write order.
  int m_cand[$];
  int m_idx[$];
  int m_addr[$];

  function automatic void build_model(input int npix, input int len, input int taps);
    int s = 1;
    m_cand.delete(); m_idx.delete(); m_addr.delete();
    do begin
      if (s < npix) begin
        m_idx.push_back(m_cand.size());
        m_addr.push_back(s);
      end
      m_cand.push_back(s);
      s = ((s << 1) & ((1 << len) - 1)) | ($countones(s & taps) & 1);
    end while (s != 1 && m_cand.size() < (1 << len));
    m_addr.push_back(0);
  endfunction

  // Cycles between accepted write k-1 and write k with an always-ready framebuffer.
  function automatic int exp_gap(input int k, input int rate_v);
    int t;
    if (k < m_idx.size()) return 2 + (m_idx[k] - m_idx[k-1] - 1) + rate_v;
    t = m_cand.size() - 1 - m_idx[m_idx.size()-1];
    return 2 + t + ((t == 0) ? 0 : rate_v);
  endfunction

  task automatic run_small(input logic [15:0] rate_v, input logic [3:0] colr_v, input int ready_pct,
                           input bit poke, input int exp_writes, input int exp_dones);
    int nw = 0, nd = 0, acc_cyc = -1, done_cyc = -1, cyc = 1;
    bit pwe = 1'b0, prdy = 1'b0, first_seen = 1'b0;
    logic [3:0] paddr = '0, pcolr = '0;
    @(negedge clk);
    s_rate = rate_v; s_colr = colr_v; s_start = 1'b1; s_ready = 1'b0;
    @(negedge clk);
    s_start = 1'b0; s_rate = 16'($urandom_range(0, 9)); s_colr = 4'($urandom);
    check("busy_after_start", s_busy, 1);
    check("we_cycle1", s_we, 0);
    while (cyc < 1000 && (done_cyc < 0 || cyc <= done_cyc + 3)) begin
      s_start = 1'b0;
      if (pwe && !prdy) begin
        check("stall_we", s_we, 1);
        check("stall_addr", s_addr, paddr);
        check("stall_colr", s_colr_o, pcolr);
      end
      if (s_we && !first_seen) begin
        first_seen = 1'b1;
        check("first_we_cycle", cyc, 2);
      end
      if (s_done) begin
        nd++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          check("done_after_last_write", cyc, acc_cyc + 1);
        end
        if (poke) s_start = 1'b1;
      end
      if (done_cyc >= 0 && cyc > done_cyc) begin
        check("idle_busy", s_busy, 0);
        check("idle_we", s_we, 0);
      end
      if (poke && cyc == 9) s_start = 1'b1;
      s_ready = ($urandom_range(0, 99) < ready_pct);
      if (s_we && s_ready) begin
        if (nw < m_addr.size()) check("addr", s_addr, m_addr[nw]);
        check("colr", s_colr_o, colr_v);
        if (ready_pct >= 100 && nw > 0) check("gap", cyc - acc_cyc, exp_gap(nw, int'(rate_v)));
        nw++;
        acc_cyc = cyc;
      end
      pwe = s_we; prdy = s_ready; paddr = s_addr; pcolr = s_colr_o;
      @(negedge clk);
      cyc++;
    end
    s_start = 1'b0;
    check("fade_completed", done_cyc >= 0, 1);
    check("writes", nw, exp_writes);
    check("done_pulses", nd, exp_dones);
`ifdef FIZZLE_FADE_PROGRESS_EN
    check("progress_small", s_prog, exp_writes);
`endif
  endtask

  typedef struct {
    logic [15:0] rate;
    logic [3:0]  colr;
    int          ready_pct;
    bit          poke;
    int          exp_writes;
    int          exp_dones;
  } vec_t;

  vec_t vecs[6];
  bit   seen[0:32767];

  initial begin
    int nacc, wt, nw, dups, oor, cbad, lastaddr, firstaddr, ndone, cyc;
    vecs[0] = '{rate: 16'd0, colr: 4'd5,  ready_pct: 100, poke: 1'b0, exp_writes: 12, exp_dones: 1};
    vecs[1] = '{rate: 16'd3, colr: 4'd9,  ready_pct: 100, poke: 1'b0, exp_writes: 12, exp_dones: 1};
    vecs[2] = '{rate: 16'd0, colr: 4'd3,  ready_pct: 50,  poke: 1'b0, exp_writes: 12, exp_dones: 1};
    vecs[3] = '{rate: 16'd2, colr: 4'd12, ready_pct: 60,  poke: 1'b0, exp_writes: 12, exp_dones: 1};
    vecs[4] = '{rate: 16'd1, colr: 4'd7,  ready_pct: 100, poke: 1'b1, exp_writes: 12, exp_dones: 1};
    vecs[5] = '{rate: 16'd0, colr: 4'd15, ready_pct: 30,  poke: 1'b1, exp_writes: 12, exp_dones: 1};
    build_model(12, 4, 'hC);

    rst = 1'b1;
    s_start = 1'b0; s_rate = '0; s_colr = '0; s_ready = 1'b0;
    l_start = 1'b0; l_rate = '0; l_colr = '0; l_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_we", s_we, 0);
    check("rst_addr", s_addr, 0);
    check("rst_colr", s_colr_o, 0);
    check("rst_busy", s_busy, 0);
    check("rst_done", s_done, 0);
    check("rst_l_we", l_we, 0);
    check("rst_l_busy", l_busy, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_small(vecs[i].rate, vecs[i].colr, vecs[i].ready_pct, vecs[i].poke,
                vecs[i].exp_writes, vecs[i].exp_dones);

    for (int i = 0; i < 4; i++)
      run_small(16'($urandom_range(0, 4)), 4'($urandom), int'($urandom_range(25, 100)),
                1'($urandom), 12, 1);

    // Reset while the 6th write is pending.
    @(negedge clk);
    s_rate = '0; s_colr = 4'd6; s_start = 1'b1; s_ready = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    nacc = 0; wt = 0;
    while (nacc < 5 && wt < 100) begin
      if (s_we) nacc++;
      @(negedge clk);
      wt++;
    end
    check("reset_test_5_writes", nacc, 5);
    s_ready = 1'b0;
    wt = 0;
    while (!s_we && wt < 20) begin
      @(negedge clk);
      wt++;
    end
    check("reset_test_we_pending", s_we, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_we", s_we, 0);
    check("midrst_busy", s_busy, 0);
    check("midrst_done", s_done, 0);
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      if (s_done || s_we) ndone++;
      @(negedge clk);
    end
    check("midrst_quiet", ndone, 0);
    run_small(16'd0, 4'd10, 100, 1'b0, 12, 1);

    // Full-size fade.
    @(negedge clk);
    l_rate = '0; l_colr = 4'd11; l_start = 1'b1; l_ready = 1'b1;
    @(negedge clk);
    l_start = 1'b0; l_colr = 4'd2;
    nw = 0; dups = 0; oor = 0; cbad = 0; lastaddr = -1; firstaddr = -1; ndone = 0; cyc = 0;
    while (ndone == 0 && cyc < 70000) begin
      if (l_we) begin
        if (seen[l_addr]) dups++;
        seen[l_addr] = 1'b1;
        if (int'(l_addr) >= 19200) oor++;
        if (l_colr_o != 4'd11) cbad++;
        if (firstaddr < 0) firstaddr = int'(l_addr);
        lastaddr = int'(l_addr);
        nw++;
      end
      if (l_done) ndone++;
      @(negedge clk);
      cyc++;
    end
    check("big_done", ndone, 1);
    check("big_writes", nw, 19200);
    check("big_dups", dups, 0);
    check("big_out_of_range", oor, 0);
    check("big_colr_bad", cbad, 0);
    check("big_first_addr", firstaddr, 1);
    check("big_last_addr", lastaddr, 0);
`ifdef FIZZLE_FADE_PROGRESS_EN
    check("big_progress", l_prog, 19200);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
